serial_frame_collector: RTL and testbench

- Downstream consumer of the sequence detector's gated serial stream (serOut / serOutValid / clkEn).
- Shifts each contiguous valid burst into a FRAME_LEN-bit parallel word and presents it on a one-entry valid/ready output buffer.
- Flags truncated bursts and buffer overflow, and counts delivered frames for the downstream parallel consumer.

---
 rtl/serial_frame_if.sv | 11 +
 rtl/serial_frame_collector.sv | 80 ++++++++
 tb/tb_serial_frame_collector.sv | 135 +++++++++++++
 3 files changed

// File: rtl/serial_frame_if.sv
// serial_frame_if: gated serial input stream plus valid/ready parallel output of the frame collector
interface serial_frame_if #(parameter int FRAME_LEN = 10, parameter int CNT_W = 8);
  logic clkEn, serIn, serInValid, dataReady, clrErr;
  logic [FRAME_LEN-1:0] dataOut;
  logic dataValid, frameAbort, overflow, parityErr;
  logic [CNT_W-1:0] frameCnt;
  modport master(output clkEn, serIn, serInValid, dataReady, clrErr,
                 input dataOut, dataValid, frameAbort, overflow, frameCnt, parityErr);
  modport slave(input clkEn, serIn, serInValid, dataReady, clrErr,
                output dataOut, dataValid, frameAbort, overflow, frameCnt, parityErr);
endinterface

// File: rtl/serial_frame_collector.sv
// serial_frame_collector: serial bursts to FRAME_LEN-bit words on a one-entry buffer; define PARITY_CHECK_EN for even-parity flag
module serial_frame_collector #(
  parameter int FRAME_LEN = 10,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  serial_frame_if.slave bus
);
  localparam int BW = $clog2(FRAME_LEN);
  typedef enum logic [1:0] {IDLE = 2'b01, RECV = 2'b10} state_t;
  state_t state;
  logic [BW-1:0] bit_cnt;
  logic [FRAME_LEN-2:0] shift;
  logic [FRAME_LEN-1:0] data_out, word;
  logic data_valid, frame_abort, overflow, parity_err;
  logic [CNT_W-1:0] frame_cnt;
  logic take, last, done, free, load;
  assign take = bus.clkEn & bus.serInValid;
  assign word = {shift, bus.serIn};
  assign last = state == RECV && bit_cnt == BW'(FRAME_LEN - 1);
  assign done = take & last;
  assign free = !data_valid | bus.dataReady;
  assign load = done & free;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bit_cnt <= '0;
      shift <= '0;
      data_out <= '0;
      data_valid <= 1'b0;
      frame_abort <= 1'b0;
      overflow <= 1'b0;
      frame_cnt <= '0;
    end else begin
      frame_abort <= 1'b0;
      if (load) begin
        data_out <= word;
        data_valid <= 1'b1;
        frame_cnt <= frame_cnt + CNT_W'(1);
      end else if (data_valid & bus.dataReady) data_valid <= 1'b0;
      if (done & !free) overflow <= 1'b1;
      else if (bus.clrErr) overflow <= 1'b0;
      if (take) shift <= word[FRAME_LEN-2:0];
      if (bus.clkEn)
        case (state)
          IDLE: if (bus.serInValid) begin
            bit_cnt <= BW'(1);
            state <= RECV;
          end
          RECV: if (!bus.serInValid) begin
            frame_abort <= 1'b1;
            bit_cnt <= '0;
            state <= IDLE;
          end else if (last) begin
            bit_cnt <= '0;
            state <= IDLE;
          end else bit_cnt <= bit_cnt + BW'(1);
          default: begin
            bit_cnt <= '0;
            state <= IDLE;
          end
        endcase
    end
  end
`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) parity_err <= 1'b0;
    else if (load) parity_err <= ^word;
  end
`else
  assign parity_err = 1'b0;
`endif
  assign bus.dataOut = data_out;
  assign bus.dataValid = data_valid;
  assign bus.frameAbort = frame_abort;
  assign bus.overflow = overflow;
  assign bus.frameCnt = frame_cnt;
  assign bus.parityErr = parity_err;
endmodule

// File: tb/tb_serial_frame_collector.sv
// tb_serial_frame_collector: directed steps with a scoreboard of expected delivered words
module tb_serial_frame_collector;
  localparam int FL = 10, CW = 8;
  logic clk = 1'b0, rst = 1'b1;
  int vectors = 0, miscompares = 0;
  logic [FL-1:0] exp_q[$];
  logic [FL-1:0] w;
  serial_frame_if #(.FRAME_LEN(FL), .CNT_W(CW)) bus();
  serial_frame_collector #(.FRAME_LEN(FL), .CNT_W(CW)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic bit_in(input logic en, input logic b, input logic v);
    bus.clkEn = en;
    bus.serIn = b;
    bus.serInValid = v;
    tick();
  endtask
  function automatic logic par(input logic [FL-1:0] x);
`ifdef PARITY_CHECK_EN
    return ^x;
`else
    return 1'b0;
`endif
  endfunction
  task automatic send_frame(input logic [FL-1:0] x, input bit push, input logic rdy_last);
    for (int i = FL - 1; i >= 0; i--) begin
      if (i == 0) bus.dataReady = rdy_last;
      bit_in(1'b1, x[i], 1'b1);
    end
    if (push) exp_q.push_back(x);
    bus.serInValid = 1'b0;
  endtask
  task automatic check_out(input string tag);
    logic [FL-1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, bus.dataValid, 1'b1);
      chk({tag, "_data"}, bus.dataOut, e);
      chk({tag, "_parity"}, bus.parityErr, par(e));
    end
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_data"}, bus.dataOut, 0);
    chk({tag, "_valid"}, bus.dataValid, 0);
    chk({tag, "_abort"}, bus.frameAbort, 0);
    chk({tag, "_ovf"}, bus.overflow, 0);
    chk({tag, "_cnt"}, bus.frameCnt, 0);
    chk({tag, "_par"}, bus.parityErr, 0);
  endtask
  initial begin
    bus.clkEn = 1'b0;
    bus.serIn = 1'b0;
    bus.serInValid = 1'b0;
    bus.dataReady = 1'b0;
    bus.clrErr = 1'b0;
    tick();
    tick();
    check_zero("reset");
    rst = 1'b0;
    bus.dataReady = 1'b1;
    w = 10'h2CE;
    for (int i = FL - 1; i >= 1; i--) bit_in(1'b1, w[i], 1'b1);
    chk("t1_pre_last_valid", bus.dataValid, 0);
    bit_in(1'b1, w[0], 1'b1);
    exp_q.push_back(w);
    check_out("t1");
    chk("t1_cnt", bus.frameCnt, 1);
    bit_in(1'b0, 1'b0, 1'b0);
    chk("t1_popped", bus.dataValid, 0);
    chk("t1_hold", bus.dataOut, 10'h2CE);
    for (int i = 0; i < 6; i++) bit_in(1'b1, i[0], 1'b1);
    bit_in(1'b1, 1'b0, 1'b0);
    chk("t2_abort", bus.frameAbort, 1);
    chk("t2_valid", bus.dataValid, 0);
    chk("t2_cnt", bus.frameCnt, 1);
    bit_in(1'b0, 1'b0, 1'b0);
    chk("t2_abort_pulse", bus.frameAbort, 0);
    bus.dataReady = 1'b0;
    send_frame(10'h2CE, 1, 1'b0);
    send_frame(10'h155, 0, 1'b0);
    chk("t3_ovf", bus.overflow, 1);
    chk("t3_cnt", bus.frameCnt, 2);
    check_out("t3_held");
    bus.clrErr = 1'b1;
    tick();
    bus.clrErr = 1'b0;
    chk("t3_clr", bus.overflow, 0);
    chk("t3_still_valid", bus.dataValid, 1);
    send_frame(10'h155, 1, 1'b1);
    check_out("t3_pop_load");
    chk("t3_pl_cnt", bus.frameCnt, 3);
    chk("t3_pl_ovf", bus.overflow, 0);
    bit_in(1'b0, 1'b0, 1'b0);
    chk("t3_drained", bus.dataValid, 0);
    w = 10'h2CE;
    for (int i = FL - 1; i >= 0; i--) begin
      bit_in(1'b1, w[i], 1'b1);
      if (i > 0) bit_in(1'b0, ~w[i], 1'b1);
    end
    exp_q.push_back(w);
    check_out("t4_gated");
    chk("t4_cnt", bus.frameCnt, 4);
    bit_in(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) bit_in(1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    bit_in(1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    check_zero("t5_rst");
    bit_in(1'b1, 1'b0, 1'b0);
    chk("t5_no_abort", bus.frameAbort, 0);
    send_frame(10'h3F0, 1, 1'b1);
    check_out("t5");
    chk("t5_cnt", bus.frameCnt, 1);
    send_frame(10'h001, 1, 1'b1);
    check_out("t6_odd");
    send_frame(10'h003, 1, 1'b1);
    check_out("t6_even");
    chk("t6_cnt", bus.frameCnt, 3);
    chk("t6_sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
